// File: rtl/tt_wokwi_434917506576906241.sv
// ---------------------------------------------------------------------------
// tt_wokwi_434917506576906241
//
// Tiny Tapeout user tile: 8-bit up/down counter with parallel nibble load and
// an on-tile hex 7-segment decoder.
//
// Ports:
//   clk      in   1  clock, all state updates on the rising edge
//   rst_n    in   1  synchronous reset, ACTIVE-HIGH despite the harness name
//   ena      in   1  tile select; 0 holds the counter (reset still applies)
//   ui_in    in   8  [0] en, [1] up, [2] load, [3] dsel, [7:4] load value
//   uio_in   in   8  unused
//   uo_out   out  8  [6:0] segments a..g (active-high), [7] terminal count
//   uio_out  out  8  counter value
//   uio_oe   out  8  constant 8'hFF (bidirectional pins always driven)
// ---------------------------------------------------------------------------
module tt_wokwi_434917506576906241 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic       en;
    logic       up;
    logic       load;
    logic       dsel;
    logic [3:0] lv;

    assign en   = ui_in[0];
    assign up   = ui_in[1];
    assign load = ui_in[2];
    assign dsel = ui_in[3];
    assign lv   = ui_in[7:4];

    // The bidirectional inputs are intentionally ignored.
    logic unused_uio_in;
    assign unused_uio_in = &{1'b0, uio_in};

    logic [7:0] cnt_reg;
    logic [7:0] cnt_next;

    // Priority: ena gate, then load, then count; reset is applied in the
    // register itself so it overrides everything including ena=0.
    always_comb begin
        cnt_next = cnt_reg;
        if (ena) begin
            if (load) begin
                cnt_next = {4'h0, lv};
            end else if (en) begin
                if (up) begin
                    cnt_next = cnt_reg + 8'd1;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_reg <= 8'h00;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Combinational nibble select, one 2:1 mux per bit.
    logic [3:0] nib;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nib
            assign nib[gi] = dsel ? cnt_reg[gi + 4] : cnt_reg[gi];
        end
    endgenerate

    // Hex to 7-segment, bit0 = a ... bit6 = g.
    logic [6:0] seg;
    always_comb begin
        seg = 7'h00;
        unique case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
        endcase
    end

    // Terminal count follows the live direction input, not a registered one.
    logic tc;
    assign tc = up ? (cnt_reg == 8'hFF) : (cnt_reg == 8'h00);

    assign uo_out  = {tc, seg};
    assign uio_out = cnt_reg;
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_wokwi_434917506576906241.sv
module tb_tt_wokwi_434917506576906241;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h02;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    tt_wokwi_434917506576906241 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // Segment table straight from the hex glyph list.
    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counter value as a plain integer.
    int  m_cnt = 0;
    bit  m_valid = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            m_cnt   = 0;
            m_valid = 1;
        end else if (ena) begin
            if (ui_in[2])      m_cnt = int'(ui_in[7:4]);
            else if (ui_in[0]) m_cnt = ui_in[1] ? (m_cnt + 1) % 256 : (m_cnt + 255) % 256;
        end
    end

    function automatic logic [7:0] model_uo();
        int nib;
        bit tc;
        nib = ui_in[3] ? m_cnt / 16 : m_cnt % 16;
        tc  = ui_in[1] ? (m_cnt == 255) : (m_cnt == 0);
        return {tc, seg_tbl[nib]};
    endfunction

    // Cycle-by-cycle compare on the falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_cnt", uio_out, 8'(m_cnt));
            check("model_uo", uo_out, model_uo());
            check("model_oe", uio_oe, 8'hFF);
            $display("cyc t=%0t rst=%0b ena=%0b ui=%02h cnt=%02h uo=%02h", $time, rst_n, ena, ui_in, uio_out, uo_out);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset with up=1
        tick(2);
        check("rst_cnt", uio_out, 8'h00);
        check("rst_uo_up", uo_out, 8'h3F);
        check("rst_oe", uio_oe, 8'hFF);
        ui_in = 8'h00;
        #1;
        check("rst_uo_down", uo_out, 8'hBF);
        rst_n = 1'b0;

        // Up count with wrap
        ui_in = 8'h03;
        for (int i = 1; i <= 256; i++) begin
            tick(1);
            check("up_step", uio_out, 8'(i % 256));
            if (i == 255) check("up_tc", {7'h0, uo_out[7]}, 8'h01);
            if (i == 15)  check("up_seg_0f", {1'b0, uo_out[6:0]}, 8'h71);
        end

        // Down count wraps from 00 to FF
        ui_in = 8'h01;
        tick(1);
        check("down_wrap", uio_out, 8'hFF);
        check("down_tc", {7'h0, uo_out[7]}, 8'h00);

        // Load beats count
        ui_in = 8'hA7;
        tick(1);
        check("load_prio", uio_out, 8'h0A);
        ui_in = 8'hA8;
        #1;
        check("dsel_hi", {1'b0, uo_out[6:0]}, 8'h3F);

        // Hold and gating
        ui_in = 8'h54;
        tick(1);
        check("load5", uio_out, 8'h05);
        ena = 1'b0;
        ui_in = 8'h03;
        tick(4);
        check("ena_hold", uio_out, 8'h05);
        ena = 1'b1;
        ui_in = 8'h02;
        tick(2);
        check("en_hold", uio_out, 8'h05);

        // Reset mid-count
        ui_in = 8'h74;
        tick(1);
        ui_in = 8'h03;
        tick(48);
        check("reach_37", uio_out, 8'h37);
        rst_n = 1'b1;
        ui_in = 8'hF7;
        tick(1);
        check("mid_reset", uio_out, 8'h00);
        rst_n = 1'b0;
        ui_in = 8'h03;
        tick(1);
        check("resume", uio_out, 8'h01);

        // Randomised traffic against the model
        for (int i = 0; i < 2000; i++) begin
            ui_in  = 8'($urandom);
            uio_in = 8'($urandom);
            ena    = ($urandom_range(0, 7) != 0);
            rst_n  = ($urandom_range(0, 63) == 0);
            tick(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tt_wokwi_434917506576906241.md
# tt_wokwi_434917506576906241

Tiny Tapeout user tile: an 8-bit up/down counter with parallel nibble load and an on-tile 7-segment decoder. The count value is driven on the bidirectional pins, which are always outputs. The selected nibble is rendered on the dedicated outputs together with a terminal-count flag. The block sits directly under the Tiny Tapeout harness, wired to the standard tile pins.

## Interface
- No parameters.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-high.
  - Port keeps the harness name, but registers clear on a rising clk edge while rst_n=1.
  - rst_n=0 is normal operation.
- ena  input  1  tile select; when 0 the counter holds (reset still applies).
- ui_in  input  8  control and load data:
  - [0] count enable (en).
  - [1] direction (up: 1=up, 0=down).
  - [2] load.
  - [3] digit select (dsel: 0=low nibble, 1=high nibble).
  - [7:4] load value (lv).
- uio_in  input  8  unused; ignored.
- uo_out  output  8  [6:0] 7-segment pattern (bit0=a … bit6=g, active-high); [7] terminal count (tc).
- uio_out  output  8  current counter value cnt[7:0].
- uio_oe  output  8  constant 8'hFF (all bidirectional pins are outputs).

## Operation
- One state register cnt[7:0]. Next-state priority per rising edge:
  1. rst_n=1 → cnt=8'h00.
  2. ena=0 → hold.
  3. load=1 → cnt={4'h0, lv} (load wins over count; en and up are ignored).
  4. en=1, up=1 → cnt+1 mod 256 (8'hFF wraps to 8'h00).
  5. en=1, up=0 → cnt−1 mod 256 (8'h00 wraps to 8'hFF).
  6. otherwise → hold.
- Nibble select: nib = dsel ? cnt[7:4] : cnt[3:0]. This path is combinational.
- Segment code (hex, bits g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- tc is combinational: 1 when (up=1 and cnt=8'hFF) or (up=0 and cnt=8'h00); otherwise 0.
- uo_out = {tc, seg(nib)}; uio_out = cnt; uio_oe = 8'hFF at all times, including during reset.
- uio_in and unused harness inputs have no effect.

## Timing
- Reset values: cnt=00, so uio_out=8'h00 and uio_oe=8'hFF.
  - uo_out=8'h3F with up=1.
  - uo_out=8'hBF with up=0, because tc=1 at cnt=00 counting down.
- Counter latency is one clock. A change on en, up, load or lv is reflected in uio_out after the next rising edge.
- Output decode latency is zero. dsel and up changes affect uo_out combinationally within the same cycle.
- Reset asserted mid-count clears cnt at the next edge regardless of load, en or ena. Counting resumes on the first edge after rst_n returns to 0.
- Simultaneous load and en: load is applied and no increment occurs that cycle.
- The design has no handshake and no multicycle paths; one state update per clock at most.

## Test plan
- Reset: hold rst_n=1 for 2 clocks with ui_in=8'h02 (up) → uio_out=00, uo_out=3F, uio_oe=FF. Then set up=0 → uo_out=BF with no clock needed.
- Up count with wrap: reset, then ui_in=8'h03, ena=1 for 256 clocks.
  - uio_out steps 01, 02, … and returns to 00.
  - At cnt=FF: uo_out[7]=1.
  - At cnt=0F with dsel=0: uo_out[6:0]=71.
- Down count with wrap: from cnt=00, ui_in=8'h01 for 1 clock → uio_out=FF; uo_out[7]=0 while cnt≠00.
- Load priority: ui_in=8'hA7 (lv=A, load=1, up=1, en=1) for 1 clock → uio_out=0A (no increment). Set dsel=1 → uo_out[6:0]=3F.
- Hold and gating:
  - cnt=05, ena=0, ui_in=8'h03 for 4 clocks → uio_out stays 05.
  - ena=1, en=0 → stays 05.
- Reset mid-operation: counting up at cnt=37, assert rst_n=1 for 1 clock with load=1 → uio_out=00 on that edge.
